// File: rtl/ibex_obi_mem_responder.sv
// Word-addressed RAM responder for the Ibex req/gnt/rvalid bus.
//
// Each granted request pushes a response entry {rdata, err, cnt} into an
// in-order queue. The entry's countdown starts at RespLatency-1+lat_extra_i
// and decrements every cycle. Only the head is presented, so responses always
// come back in grant order.
//
// Handshake: gnt_o is a combinational accept in the same cycle as req_i.
// rvalid_o has no back-pressure. The head entry retires at the clock edge that
// ends every cycle in which rvalid_o is high.
module ibex_obi_mem_responder #(
    parameter int          AddrWidth      = 32,
    parameter int          DepthWords     = 4096,
    parameter logic [31:0] BaseAddr       = 32'h00100000,
    parameter int          RespLatency    = 1,
    parameter int          ExtraLatWidth  = 2,
    parameter int          MaxOutstanding = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_i,
    output logic                              gnt_o,
    input  logic [AddrWidth-1:0]              addr_i,
    input  logic                              we_i,
    input  logic [3:0]                        be_i,
    input  logic [31:0]                       wdata_i,
    output logic                              rvalid_o,
    output logic [31:0]                       rdata_o,
    output logic                              err_o,
    input  logic                              stall_i,
    input  logic [ExtraLatWidth-1:0]          lat_extra_i,
    input  logic                              load_we_i,
    input  logic [$clog2(DepthWords)-1:0]     load_addr_i,
    input  logic [31:0]                       load_wdata_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);

    localparam int WordIdxW = $clog2(DepthWords);
    localparam int OutW     = $clog2(MaxOutstanding + 1);
    localparam int PtrW     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    // Wide enough for the largest load value, RespLatency-1 + (2**ExtraLatWidth - 1).
    localparam int CntW     = $clog2(RespLatency + (1 << ExtraLatWidth)) + 1;

    localparam logic [AddrWidth-1:0] Base = AddrWidth'(BaseAddr);
    localparam logic [AddrWidth:0]   Span = (AddrWidth + 1)'(4 * DepthWords);

    logic [31:0]           mem [DepthWords];

    logic [31:0]           q_rdata [MaxOutstanding];
    logic                  q_err   [MaxOutstanding];
    logic [CntW-1:0]       q_cnt   [MaxOutstanding];
    logic [PtrW-1:0]       head;
    logic [PtrW-1:0]       tail;
    logic [OutW-1:0]       count;

    logic [AddrWidth-1:0]  offset;
    logic                  in_range;
    logic [WordIdxW-1:0]   word_idx;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  head_ready;
    logic [31:0]           push_rdata;
    logic [CntW-1:0]       cnt_load;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Address decode. addr_i[1:0] only feeds the range compare; it does not select a byte.
    always_comb begin
        offset   = addr_i - Base;
        in_range = (addr_i >= Base) && ({1'b0, offset} < Span);
        word_idx = offset[WordIdxW+1:2];
    end

    // Grant, response presentation and the contents of the entry being pushed.
    always_comb begin
        full       = (count == OutW'(MaxOutstanding));
        gnt_o      = req_i & ~stall_i & ~rst_i & ~full;
        push       = gnt_o;
        head_ready = (count != '0) && (q_cnt[head] == '0);
        rvalid_o   = ~rst_i & head_ready;
        pop        = rvalid_o;
        rdata_o    = rvalid_o ? q_rdata[head] : 32'h0;
        err_o      = rvalid_o ? q_err[head] : 1'b0;
        push_rdata = (in_range && !we_i) ? mem[word_idx] : 32'h0;
        cnt_load   = CntW'(RespLatency - 1) + CntW'(lat_extra_i);
        outstanding_o = count;
    end

    // RAM update. The backdoor write comes last, so it wins when it hits the same word as a bus write.
    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (load_we_i) mem[load_addr_i] <= load_wdata_i;
    end

    // Response queue: countdown on every entry, push at grant, pop of the head on rvalid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                q_rdata[i] <= 32'h0;
                q_err[i]   <= 1'b0;
                q_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                if (q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - 1'b1;
            end
            if (push) begin
                q_rdata[tail] <= push_rdata;
                q_err[tail]   <= ~in_range;
                q_cnt[tail]   <= cnt_load;
                tail          <= ptr_next(tail);
            end
            if (pop) head <= ptr_next(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_obi_mem_responder.sv
// Directed bench for ibex_obi_mem_responder with the default parameters.
module tb_ibex_obi_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        stall_i;
    logic [1:0]  lat_extra_i;
    logic        load_we_i;
    logic [11:0] load_addr_i;
    logic [31:0] load_wdata_i;
    logic [2:0]  outstanding_o;

    int total = 0;
    int bad   = 0;

    ibex_obi_mem_responder dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .stall_i(stall_i), .lat_extra_i(lat_extra_i),
        .load_we_i(load_we_i), .load_addr_i(load_addr_i), .load_wdata_i(load_wdata_i),
        .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change at posedge+1; outputs are sampled at the following negedge.
    task automatic load_word(input logic [11:0] idx, input logic [31:0] data);
        load_we_i = 1'b1; load_addr_i = idx; load_wdata_i = data;
        @(posedge clk_i); #1;
        load_we_i = 1'b0;
    endtask

    // Holds req until granted (bounded). waits = cycles spent before the grant; -1 if never granted.
    task automatic bus_issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                             input logic [31:0] d, input logic [1:0] x, output int waits);
        bit g = 0;
        waits = -1;
        req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = d; lat_extra_i = x;
        for (int n = 0; n < 20 && !g; n++) begin
            @(negedge clk_i);
            if (gnt_o) begin g = 1; waits = n; end
            @(posedge clk_i); #1;
        end
        req_i = 1'b0; we_i = 1'b0; lat_extra_i = 2'd0;
    endtask

    // Waits (bounded) for rvalid. lat = cycles after the grant cycle; -1 on timeout.
    task automatic wait_rvalid(output logic [31:0] rd, output logic er, output int lat);
        bit seen = 0;
        lat = -1; rd = 32'hx; er = 1'bx;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk_i);
            if (rvalid_o) begin seen = 1; rd = rdata_o; er = err_o; lat = n + 1; end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b1; addr_i = 32'h00100000; we_i = 1'b0; be_i = 4'h0;
        wdata_i = 32'h0; stall_i = 1'b0; lat_extra_i = 2'd0;
        load_we_i = 1'b0; load_addr_i = '0; load_wdata_i = '0;
        @(posedge clk_i); @(posedge clk_i); #1;
        @(negedge clk_i);
        total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0", gnt_o); end
        total++; if (rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", rvalid_o); end
        total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding_o); end
        total++; if (rdata_o !== 32'h0 || err_o !== 1'b0) begin bad++; $display("FAIL reset_rdata_err got=%h/%b exp=0/0", rdata_o, err_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0; req_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_backdoor_read();
        int w; int lat; logic [31:0] rd; logic er;
        load_word(12'd0, 32'h00702503);
        bus_issue(32'h00100000, 1'b0, 4'h0, 32'h0, 2'd0, w);
        total++; if (w !== 0) begin bad++; $display("FAIL bd_gnt_wait got=%0d exp=0", w); end
        wait_rvalid(rd, er, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL bd_latency got=%0d exp=1", lat); end
        total++; if (rd !== 32'h00702503) begin bad++; $display("FAIL bd_rdata got=%h exp=00702503", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL bd_err got=%b exp=0", er); end
        @(negedge clk_i);
        total++; if (rvalid_o !== 1'b0 || outstanding_o !== 3'd0) begin bad++; $display("FAIL bd_drained got=%b/%0d exp=0/0", rvalid_o, outstanding_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_write_be();
        int w; int lat; logic [31:0] rd; logic er;
        load_word(12'd4, 32'h11223344);
        bus_issue(32'h00100010, 1'b1, 4'b0101, 32'hAABBCCDD, 2'd0, w);
        wait_rvalid(rd, er, lat);
        total++; if (lat !== 1 || rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL wr_resp got=lat%0d %h/%b exp=lat1 0/0", lat, rd, er); end
        bus_issue(32'h00100010, 1'b0, 4'h0, 32'h0, 2'd0, w);
        wait_rvalid(rd, er, lat);
        total++; if (rd !== 32'h11BB33DD || er !== 1'b0) begin bad++; $display("FAIL wr_be_merge got=%h/%b exp=11bb33dd/0", rd, er); end
        // be=0 write is a no-op
        bus_issue(32'h00100010, 1'b1, 4'b0000, 32'hFFFFFFFF, 2'd0, w);
        wait_rvalid(rd, er, lat);
        bus_issue(32'h00100012, 1'b0, 4'h0, 32'h0, 2'd0, w);
        wait_rvalid(rd, er, lat);
        total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL wr_be0_noop got=%h exp=11bb33dd", rd); end
        // Backdoor and bus write to the same word in the same cycle: backdoor wins
        load_we_i = 1'b1; load_addr_i = 12'd5; load_wdata_i = 32'h12345678;
        bus_issue(32'h00100014, 1'b1, 4'hF, 32'hFFFFFFFF, 2'd0, w);
        load_we_i = 1'b0;
        wait_rvalid(rd, er, lat);
        bus_issue(32'h00100014, 1'b0, 4'h0, 32'h0, 2'd0, w);
        wait_rvalid(rd, er, lat);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL bd_wins got=%h exp=12345678", rd); end
    endtask

    task automatic test_out_of_range();
        int w; int lat; logic [31:0] rd; logic er;
        bus_issue(32'h000FFFFC, 1'b0, 4'h0, 32'h0, 2'd0, w);
        wait_rvalid(rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL oor_low got=%h/%b exp=0/1", rd, er); end
        bus_issue(32'h00104000, 1'b0, 4'h0, 32'h0, 2'd0, w);
        wait_rvalid(rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL oor_high got=%h/%b exp=0/1", rd, er); end
        bus_issue(32'h00104000, 1'b1, 4'hF, 32'hDEADBEEF, 2'd0, w);
        wait_rvalid(rd, er, lat);
        total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL oor_write got=%h/%b exp=0/1", rd, er); end
        bus_issue(32'h00100000, 1'b0, 4'h0, 32'h0, 2'd0, w);
        wait_rvalid(rd, er, lat);
        total++; if (rd !== 32'h00702503 || er !== 1'b0) begin bad++; $display("FAIL oor_ram_kept got=%h/%b exp=00702503/0", rd, er); end
        load_word(12'd4095, 32'hCAFEF00D);
        bus_issue(32'h00103FFC, 1'b0, 4'h0, 32'h0, 2'd0, w);
        wait_rvalid(rd, er, lat);
        total++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin bad++; $display("FAIL last_word got=%h/%b exp=cafef00d/0", rd, er); end
    endtask

    task automatic test_in_order();
        logic [31:0] vals [3];
        logic [1:0]  ext  [3];
        logic        rv   [10];
        logic [31:0] rd   [10];
        logic        g    [3];
        vals[0] = 32'hA0000001; vals[1] = 32'hB0000002; vals[2] = 32'hC0000003;
        ext[0] = 2'd3; ext[1] = 2'd0; ext[2] = 2'd0;
        for (int i = 0; i < 3; i++) load_word(12'(i + 1), vals[i]);
        for (int c = 0; c < 10; c++) begin
            if (c < 3) begin
                req_i = 1'b1; we_i = 1'b0; addr_i = 32'h00100000 + 32'((c + 1) * 4); lat_extra_i = ext[c];
            end else begin
                req_i = 1'b0; lat_extra_i = 2'd0;
            end
            @(negedge clk_i);
            if (c < 3) g[c] = gnt_o;
            rv[c] = rvalid_o; rd[c] = rdata_o;
            @(posedge clk_i); #1;
        end
        for (int c = 0; c < 3; c++) begin
            total++; if (g[c] !== 1'b1) begin bad++; $display("FAIL order_gnt c=%0d got=%b exp=1", c, g[c]); end
        end
        for (int c = 0; c < 10; c++) begin
            logic er; logic [31:0] ed;
            er = (c >= 4 && c <= 6);
            ed = er ? vals[c - 4] : 32'h0;
            total++;
            if (rv[c] !== er || rd[c] !== ed) begin
                bad++; $display("FAIL order_rsp c=%0d got=%b/%h exp=%b/%h", c, rv[c], rd[c], er, ed);
            end
        end
    endtask

    task automatic test_back_to_back_full();
        logic [2:0] exp_out [8];
        logic       exp_gnt [7];
        logic [2:0] out_s   [8];
        logic       gnt_s   [7];
        bit drained = 0;
        exp_out[0] = 3'd0; exp_out[1] = 3'd1; exp_out[2] = 3'd2; exp_out[3] = 3'd3;
        exp_out[4] = 3'd4; exp_out[5] = 3'd3; exp_out[6] = 3'd3; exp_out[7] = 3'd2;
        exp_gnt[0] = 1; exp_gnt[1] = 1; exp_gnt[2] = 1; exp_gnt[3] = 1;
        exp_gnt[4] = 0; exp_gnt[5] = 1; exp_gnt[6] = 0;
        for (int c = 0; c < 8; c++) begin
            req_i = (c < 7); we_i = 1'b0; addr_i = 32'h00100000; lat_extra_i = 2'd3;
            stall_i = (c >= 6);
            @(negedge clk_i);
            out_s[c] = outstanding_o;
            if (c < 7) gnt_s[c] = gnt_o;
            @(posedge clk_i); #1;
        end
        req_i = 1'b0; stall_i = 1'b0; lat_extra_i = 2'd0;
        for (int c = 0; c < 7; c++) begin
            total++; if (gnt_s[c] !== exp_gnt[c]) begin bad++; $display("FAIL full_gnt c=%0d got=%b exp=%b", c, gnt_s[c], exp_gnt[c]); end
        end
        for (int c = 0; c < 8; c++) begin
            total++; if (out_s[c] !== exp_out[c]) begin bad++; $display("FAIL full_outstanding c=%0d got=%0d exp=%0d", c, out_s[c], exp_out[c]); end
        end
        for (int n = 0; n < 30 && !drained; n++) begin
            @(negedge clk_i);
            if (outstanding_o == 3'd0 && !rvalid_o) drained = 1;
            @(posedge clk_i); #1;
        end
        total++; if (!drained) begin bad++; $display("FAIL full_drain got=%0d exp=0", outstanding_o); end
    endtask

    task automatic test_reset_midflight();
        int rv_count = 0;
        int w; int lat; logic [31:0] rd; logic er;
        for (int c = 0; c < 3; c++) begin
            req_i = 1'b1; we_i = 1'b0; addr_i = 32'h00100000; lat_extra_i = 2'd3;
            @(posedge clk_i); #1;
        end
        req_i = 1'b0; lat_extra_i = 2'd0;
        @(negedge clk_i);
        total++; if (outstanding_o !== 3'd3) begin bad++; $display("FAIL mid_pre_outstanding got=%0d exp=3", outstanding_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL mid_post_outstanding got=%0d exp=0", outstanding_o); end
        @(posedge clk_i); #1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (rvalid_o) rv_count++;
            @(posedge clk_i); #1;
        end
        total++; if (rv_count !== 0) begin bad++; $display("FAIL mid_stale_rvalid got=%0d exp=0", rv_count); end
        bus_issue(32'h00100010, 1'b0, 4'h0, 32'h0, 2'd0, w);
        wait_rvalid(rd, er, lat);
        total++; if (rd !== 32'h11BB33DD || er !== 1'b0) begin bad++; $display("FAIL mid_ram_kept got=%h/%b exp=11bb33dd/0", rd, er); end
    endtask

    initial begin
        test_reset();
        test_backdoor_read();
        test_write_be();
        test_out_of_range();
        test_in_order();
        test_back_to_back_full();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
